inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 128, meaning number of instruction words stored.
REQ-003 The block SHALL have parameter LATENCY, default 1, legal values 1 or 2, meaning cycles from fetch accept to inst_valid.
REQ-004 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning the word returned on a faulted fetch.
REQ-005 AW SHALL equal $clog2(DEPTH) and is derived, not user-set.

Interface
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 fetch_req  in  1  fetch request.
REQ-009 fetch_addr  in  32  byte address (PC).
REQ-010 fetch_ready  out  1  fetch accepted this cycle when high with fetch_req.
REQ-011 inst_valid  out  1  inst_out/fault valid, one-cycle pulse per accepted fetch.
REQ-012 inst_out  out  DATA_W  fetched instruction word.
REQ-013 fault  out  2  bit0 misaligned, bit1 out-of-range; qualified by inst_valid.
REQ-014 halted  out  1  sticky end-of-program flag.
REQ-015 load_en  in  1  program-load write strobe.
REQ-016 load_addr  in  AW  word index for load.
REQ-017 load_data  in  DATA_W  word written on load.
REQ-018 fetch_count  out  32  number of accepted fetches.

Function
REQ-019 Word index SHALL be fetch_addr >> 2; byte offset fetch_addr[1:0] SHALL be ignored for indexing.
REQ-020 fetch_ready SHALL equal !load_en && !halted (combinational).
REQ-021 Accept = fetch_req && fetch_ready; one fetch accepted per cycle max, fully pipelined, no back-pressure on output.
REQ-022 For each accept at edge N, inst_valid SHALL be 1 during the cycle after edge N+LATENCY-1 (LATENCY=1: next cycle), with inst_out/fault for that address; order preserved.
REQ-023 inst_valid SHALL be 0 in every cycle not covered by REQ-022.
REQ-024 fault[0] SHALL be set when fetch_addr[1:0] != 0.
REQ-025 fault[1] SHALL be set when (fetch_addr >> 2) >= DEPTH, compared at full 32-bit width (no truncation/wrap).
REQ-026 Any faulted fetch SHALL return inst_out = NOP_WORD; a non-faulted fetch returns memory contents.
REQ-027 An accepted out-of-range fetch SHALL set halted at the same edge it is accepted; halted stays 1 until reset.
REQ-028 Fetches already in flight when halted sets SHALL still complete and deliver inst_valid.
REQ-029 load_en SHALL write load_data to word load_addr at the rising edge; load has priority over fetch (fetch_ready low).
REQ-030 A fetch accepted the cycle after a load to the same index SHALL return the newly loaded word.
REQ-031 Loads SHALL be accepted while halted.
REQ-032 fetch_count SHALL increment by 1 per accept and saturate at 32'hFFFF_FFFF.
REQ-033 inst_out SHALL hold its last value when inst_valid is 0.

Reset
REQ-034 rst_n low SHALL immediately force inst_valid=0, fault=0, inst_out=0, halted=0, fetch_count=0, and clear all in-flight pipeline stages.
REQ-035 Memory contents SHALL NOT be altered by reset.
REQ-036 Fetches in flight at reset assertion SHALL be dropped, never delivered after release.
REQ-037 First accept SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-038 Load words 0..3 with 32'hA0..A3, fetch addr 0,4,8,12 back-to-back (LATENCY=1) -> inst_valid 4 consecutive cycles, inst_out A0,A1,A2,A3, fault 0, fetch_count 4.
REQ-039 LATENCY=2, fetch addr 8 -> inst_valid exactly 2 cycles after accept, inst_out = word 2, single-cycle pulse.
REQ-040 Fetch addr 6 -> inst_out = word 1 index rule? No: inst_out NOP_WORD, fault=2'b01, halted stays 0.
REQ-041 DEPTH=128, fetch addr 512 then addr 0 -> first: NOP_WORD, fault=2'b10, halted=1; fetch_ready=0 next cycle, addr 0 not accepted, fetch_count 1.
REQ-042 load_en and fetch_req same cycle at index 5 (data 32'hDEAD) -> fetch not accepted; next-cycle fetch addr 20 returns 32'hDEAD.
REQ-043 LATENCY=2, accept fetch, assert rst_n low next cycle for 1 cycle -> no inst_valid ever issued for that fetch, all outputs zero, memory still holds prior data.

Source files
------------

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: word-addressed program store with a 1- or 2-stage
// read pipeline, fault tagging, sticky halt on out-of-range fetch and an accept counter.
module inst_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 128,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000,
    localparam int               AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [1:0]        fault,
    output logic              halted,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [31:0]       fetch_count
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              halted_r;
    logic [31:0]       count_r;

    logic              ready_s;
    logic              accept_s;
    logic [1:0]        fault_s;
    logic [DATA_W-1:0] rdata_s;

    logic              p1_valid_r;
    logic [1:0]        p1_fault_r;
    logic [DATA_W-1:0] p1_data_r;

    logic              stg_valid_s;
    logic [1:0]        stg_fault_s;
    logic [DATA_W-1:0] stg_data_s;

    logic              out_valid_r;
    logic [1:0]        out_fault_r;
    logic [DATA_W-1:0] out_data_r;

    // bit0 = misaligned PC, bit1 = word index beyond the store (full 32-bit compare, no wrap)
    function automatic logic [1:0] fetch_fault(input logic [31:0] addr);
        logic [31:0] idx;
        idx         = addr >> 2;
        fetch_fault = {(idx >= 32'(DEPTH)), (addr[1:0] != 2'b00)};
    endfunction

    // Accept decode and memory read; loads own the cycle, so fetch backs off
    always_comb begin
        ready_s  = !load_en && !halted_r;
        accept_s = fetch_req && ready_s;
        fault_s  = fetch_fault(fetch_addr);
        if (fault_s != 2'b00) begin
            rdata_s = NOP_WORD;
        end else begin
            rdata_s = mem_r[fetch_addr[AW+1:2]];
        end
    end

    // Select what feeds the output register: the live read, or the extra stage
    always_comb begin
        stg_valid_s = 1'b0;
        stg_fault_s = 2'b00;
        stg_data_s  = '0;
        if (LATENCY == 2) begin
            stg_valid_s = p1_valid_r;
            stg_fault_s = p1_fault_r;
            stg_data_s  = p1_data_r;
        end else begin
            stg_valid_s = accept_s;
            stg_fault_s = fault_s;
            stg_data_s  = rdata_s;
        end
    end

    // Program store write port; deliberately outside reset so contents survive it
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Read pipeline; data/fault registers only move on a valid beat so inst_out holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_r  <= 1'b0;
            p1_fault_r  <= 2'b00;
            p1_data_r   <= '0;
            out_valid_r <= 1'b0;
            out_fault_r <= 2'b00;
            out_data_r  <= '0;
        end else begin
            p1_valid_r <= accept_s;
            if (accept_s) begin
                p1_fault_r <= fault_s;
                p1_data_r  <= rdata_s;
            end
            out_valid_r <= stg_valid_s;
            if (stg_valid_s) begin
                out_fault_r <= stg_fault_s;
                out_data_r  <= stg_data_s;
            end
        end
    end

    // Sticky halt on an accepted out-of-range fetch, and saturating accept counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
            count_r  <= 32'h0000_0000;
        end else begin
            if (accept_s && fault_s[1]) begin
                halted_r <= 1'b1;
            end
            if (accept_s && (count_r != 32'hFFFF_FFFF)) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign fetch_ready = ready_s;
    assign inst_valid  = out_valid_r;
    assign inst_out    = out_data_r;
    assign fault       = out_fault_r;
    assign halted      = halted_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem: one LATENCY=1 and one LATENCY=2 instance share the same
// stimulus; a table of directed vectors, hand sequences and a random run against a reference model.
module tb_inst_fetch_mem;

    localparam int DEPTH = 128;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [31:0] load_data;

    logic        r1, v1, h1, r2, v2, h2;
    logic [31:0] o1, c1, o2, c2;
    logic [1:0]  f1, f2;

    always #5 clk = ~clk;

    inst_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(r1), .inst_valid(v1), .inst_out(o1), .fault(f1), .halted(h1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .fetch_count(c1)
    );

    inst_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(2), .NOP_WORD(NOP)) dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(r2), .inst_valid(v2), .inst_out(o2), .fault(f2), .halted(h2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .fetch_count(c2)
    );

    // reference model state
    logic [31:0] mem_m [DEPTH];
    logic        halted_m;
    logic [31:0] count_m;
    logic        va, vb;            // fetch results one and two edges old
    logic [31:0] da, db;
    logic [1:0]  fa, fb;
    logic [31:0] h1o, h2o;          // last delivered word per latency
    logic [1:0]  h1f, h2f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ld;
        logic [6:0]  la;
        logic [31:0] ldd;
        logic        ev;
        logic [31:0] eo;
        logic [1:0]  ef;
        logic        eh;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        halted_m = 1'b0;
        count_m  = 32'h0;
        va = 1'b0; vb = 1'b0;
        da = 32'h0; db = 32'h0;
        fa = 2'b00; fb = 2'b00;
        h1o = 32'h0; h2o = 32'h0;
        h1f = 2'b00; h2f = 2'b00;
    endtask

    task automatic check_outs();
        chk("valid_l1", 32'(v1), 32'(va));
        chk("inst_l1", o1, h1o);
        if (va) chk("fault_l1", 32'(f1), 32'(h1f));
        chk("valid_l2", 32'(v2), 32'(vb));
        chk("inst_l2", o2, h2o);
        if (vb) chk("fault_l2", 32'(f2), 32'(h2f));
        chk("halted_l1", 32'(h1), 32'(halted_m));
        chk("halted_l2", 32'(h2), 32'(halted_m));
        chk("count_l1", c1, count_m);
        chk("count_l2", c2, count_m);
    endtask

    // one clock cycle of stimulus, model update and output check
    task automatic cyc(input logic req, input logic [31:0] addr, input logic ld,
                       input logic [6:0] la, input logic [31:0] ldd);
        logic        acc;
        logic [31:0] idx;
        logic [1:0]  flt;
        logic [31:0] res;
        @(negedge clk);
        fetch_req = req; fetch_addr = addr; load_en = ld; load_addr = la; load_data = ldd;
        #1;
        chk("ready_l1", 32'(r1), 32'(!ld && !halted_m));
        chk("ready_l2", 32'(r2), 32'(!ld && !halted_m));
        acc = req && !ld && !halted_m;
        idx = addr / 32'd4;
        flt = {(idx >= 32'(DEPTH)), (addr % 32'd4 != 32'd0)};
        res = (flt != 2'b00) ? NOP : mem_m[idx[6:0]];
        @(posedge clk);
        if (acc) begin h1o = res; h1f = flt; end
        vb = va; db = da; fb = fa;
        va = acc; da = res; fa = flt;
        if (vb) begin h2o = db; h2f = fb; end
        if (ld) mem_m[la] = ldd;
        if (acc && flt[1]) halted_m = 1'b1;
        if (acc && count_m != 32'hFFFF_FFFF) count_m = count_m + 32'd1;
        #1;
        check_outs();
    endtask

    // async reset pulse spanning one rising edge; released just before the next cycle's stimulus
    task automatic do_reset();
        @(negedge clk);
        fetch_req = 1'b0; load_en = 1'b0; rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_valid_l1", 32'(v1), 32'h0);
        chk("rst_inst_l1", o1, 32'h0);
        chk("rst_fault_l1", 32'(f1), 32'h0);
        chk("rst_valid_l2", 32'(v2), 32'h0);
        chk("rst_inst_l2", o2, 32'h0);
        chk("rst_fault_l2", 32'(f2), 32'h0);
        check_outs();
        @(posedge clk);
        #1;
        chk("rst_hold_valid_l2", 32'(v2), 32'h0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int k;
        fetch_req = 1'b0; fetch_addr = 32'h0; load_en = 1'b0; load_addr = 7'h0; load_data = 32'h0;
        model_clear();

        tbl[0]  = '{1'b0, 32'd0,   1'b1, 7'd0, 32'hA0,   1'b0, 32'h0,    2'b00, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 32'd4,   1'b1, 7'd1, 32'hA1,   1'b0, 32'h0,    2'b00, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 32'd0,   1'b1, 7'd2, 32'hA2,   1'b0, 32'h0,    2'b00, 1'b0, 32'd0};
        tbl[3]  = '{1'b0, 32'd0,   1'b1, 7'd3, 32'hA3,   1'b0, 32'h0,    2'b00, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 32'd0,   1'b0, 7'd0, 32'h0,    1'b1, 32'hA0,   2'b00, 1'b0, 32'd1};
        tbl[5]  = '{1'b1, 32'd4,   1'b0, 7'd0, 32'h0,    1'b1, 32'hA1,   2'b00, 1'b0, 32'd2};
        tbl[6]  = '{1'b1, 32'd8,   1'b0, 7'd0, 32'h0,    1'b1, 32'hA2,   2'b00, 1'b0, 32'd3};
        tbl[7]  = '{1'b1, 32'd12,  1'b0, 7'd0, 32'h0,    1'b1, 32'hA3,   2'b00, 1'b0, 32'd4};
        tbl[8]  = '{1'b0, 32'd0,   1'b0, 7'd0, 32'h0,    1'b0, 32'hA3,   2'b00, 1'b0, 32'd4};
        tbl[9]  = '{1'b1, 32'd6,   1'b0, 7'd0, 32'h0,    1'b1, NOP,      2'b01, 1'b0, 32'd5};
        tbl[10] = '{1'b1, 32'd20,  1'b1, 7'd5, 32'hDEAD, 1'b0, NOP,      2'b00, 1'b0, 32'd5};
        tbl[11] = '{1'b1, 32'd20,  1'b0, 7'd0, 32'h0,    1'b1, 32'hDEAD, 2'b00, 1'b0, 32'd6};
        tbl[12] = '{1'b1, 32'd512, 1'b0, 7'd0, 32'h0,    1'b1, NOP,      2'b10, 1'b1, 32'd7};
        tbl[13] = '{1'b1, 32'd0,   1'b0, 7'd0, 32'h0,    1'b0, NOP,      2'b00, 1'b1, 32'd7};
        tbl[14] = '{1'b0, 32'd0,   1'b1, 7'd7, 32'h77,   1'b0, NOP,      2'b00, 1'b1, 32'd7};

        do_reset();

        // fill the whole store so every later fetch has defined contents
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'b1, 7'(i), $urandom);
        end

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].req, tbl[i].addr, tbl[i].ld, tbl[i].la, tbl[i].ldd);
            chk($sformatf("tbl%0d_valid", i), 32'(v1), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_inst", i), o1, tbl[i].eo);
            if (tbl[i].ev) chk($sformatf("tbl%0d_fault", i), 32'(f1), 32'(tbl[i].ef));
            chk($sformatf("tbl%0d_halted", i), 32'(h1), 32'(tbl[i].eh));
            chk($sformatf("tbl%0d_count", i), c1, tbl[i].ec);
        end

        do_reset();

        // two-cycle latency: single pulse exactly on the second edge after accept
        cyc(1'b1, 32'd8, 1'b0, 7'd0, 32'h0);
        chk("lat2_edge1_valid", 32'(v2), 32'h0);
        cyc(1'b0, 32'd0, 1'b0, 7'd0, 32'h0);
        chk("lat2_edge2_valid", 32'(v2), 32'h1);
        chk("lat2_edge2_inst", o2, 32'hA2);
        cyc(1'b0, 32'd0, 1'b0, 7'd0, 32'h0);
        chk("lat2_edge3_valid", 32'(v2), 32'h0);

        // word loaded while halted survives the reset
        cyc(1'b1, 32'd28, 1'b0, 7'd0, 32'h0);
        chk("load_while_halted", o1, 32'h77);

        // reset with a fetch in flight: it must never surface
        cyc(1'b1, 32'd0, 1'b0, 7'd0, 32'h0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'd0, 1'b0, 7'd0, 32'h0);
            chk("dropped_inflight_l2", 32'(v2), 32'h0);
        end
        cyc(1'b1, 32'd4, 1'b0, 7'd0, 32'h0);
        chk("mem_kept_over_reset", o1, 32'hA1);

        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 99);
            if (k < 75)      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            else if (k < 87) a = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
            else if (k < 90) a = 32'h0000_01FC;
            else if (k < 93) a = 32'h0000_0200;
            else if (k < 96) a = 32'h4000_0000;
            else if (k < 98) a = 32'hFFFF_FFFC;
            else             a = 32'h0000_0200 + $urandom_range(0, 32'h0FFF_FFFF);
            cyc(1'($urandom_range(0, 99) < 75), a, 1'($urandom_range(0, 99) < 12),
                7'($urandom_range(0, DEPTH - 1)), $urandom);
            if ((halted_m && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
